// File: rtl/vec_alu_seq_pkg.sv
// vec_alu_seq_pkg: shared vector types, ALU encodings and SEW decode
package vec_alu_seq_pkg;
  typedef enum logic [1:0] {E8, E16, E32, E64} vsew_e;
  typedef enum logic [2:0] {OP_VV = 3'b001, OP_VX = 3'b010, OP_VI = 3'b100} op_type_e;
  localparam logic [5:0] ALU_VADD = 6'b000000;
  localparam logic [5:0] ALU_VAND = 6'b001001;
  localparam logic [5:0] ALU_VOR  = 6'b001010;
  localparam logic [5:0] ALU_VXOR = 6'b001011;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic logic [6:0] sew_bits(input logic [1:0] vsew);
    return 7'd8 << vsew;
  endfunction
endpackage

// File: rtl/vec_elem_counter.sv
// vec_elem_counter: elem/chunk walk and bit-index generation for the ALU
module vec_elem_counter
  import vec_alu_seq_pkg::*;
#(
  parameter int LANE_WIDTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       step,
  input  logic [1:0] vsew,
  input  logic [9:0] vl_eff,
  output logic [9:0] index,
  output logic [3:0] chunk,
  output logic [6:0] cw,
  output logic       last
);
  localparam logic [6:0] LANE = 7'(1 << LANE_WIDTH);
  logic [6:0] sew;
  logic [3:0] chunks;
  logic [9:0] elem;
  assign sew    = sew_bits(vsew);
  assign chunks = sew > LANE ? 4'(sew >> LANE_WIDTH) : 4'd1;
  assign cw     = sew > LANE ? LANE : sew;
  assign last   = elem == vl_eff - 10'd1 && chunk == chunks - 4'd1;
  // chunks are contiguous, so the bit index simply advances by cw per step
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      elem  <= '0;
      chunk <= '0;
      index <= '0;
    end else if (step) begin
      index <= index + 10'(cw);
      chunk <= chunk == chunks - 4'd1 ? 4'd0 : chunk + 4'd1;
      elem  <= chunk == chunks - 4'd1 ? elem + 10'd1 : elem;
    end
  end
endmodule

// File: rtl/vec_alu_seq.sv
// vec_alu_seq: sequences the single-lane vector ALU and packs its results
module vec_alu_seq
  import vec_alu_seq_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [9:0]      vl,
  input  logic [2:0]      vsew,
  input  logic [VLEN-1:0] vd_old,
  output logic            alu_run,
  output logic [9:0]      alu_index,
  output logic [3:0]      alu_in_reg_offset,
  input  logic [63:0]     alu_vd,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [VLEN-1:0] result,
  output logic            err
);
  state_e state, next_state;
  logic [2:0] vsew_q;
  logic [9:0] vl_q, vlmax, vl_eff;
  logic [6:0] cw;
  logic [63:0] cw_mask;
  logic [VLEN-1:0] wr_mask, wr_data;
  logic accept, last;
  assign start_ready = state == IDLE;
  assign alu_run     = state == RUN;
  assign res_valid   = state == DONE;
  assign accept      = start_valid && start_ready;
  assign vlmax       = 10'(VLEN / 8) >> vsew[1:0];
  assign vl_eff      = vl < vlmax ? vl : vlmax;
  // a shift by 64 wraps to zero, so the subtract still yields an all-ones mask
  assign cw_mask     = (64'd1 << cw) - 64'd1;
  assign wr_mask     = VLEN'(cw_mask) << alu_index;
  assign wr_data     = VLEN'(alu_vd & cw_mask) << alu_index;
  vec_elem_counter #(.LANE_WIDTH(LANE_WIDTH)) u_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clear  (accept),
    .step   (alu_run),
    .vsew   (vsew_q[1:0]),
    .vl_eff (vl_q),
    .index  (alu_index),
    .chunk  (alu_in_reg_offset),
    .cw     (cw),
    .last   (last)
  );
  always_ff @(posedge clk) state <= !resetn ? IDLE : next_state;
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    next_state = accept ? ((vsew[2] || vl_eff == 10'd0) ? DONE : RUN) : IDLE;
      RUN:     next_state = last ? DONE : RUN;
      DONE:    next_state = res_ready ? IDLE : DONE;
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      result <= '0;
      err    <= 1'b0;
      vsew_q <= '0;
      vl_q   <= '0;
    end else if (accept) begin
      result <= vd_old;
      err    <= vsew[2];
      vsew_q <= vsew;
      vl_q   <= vl_eff;
    end else if (alu_run) begin
      result <= (result & ~wr_mask) | wr_data;
    end else if (res_valid && res_ready) begin
      err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vec_alu_seq.sv
// tb_vec_alu_seq: randomized self-checking bench with a chunked-add ALU stub
module tb_vec_alu_seq;
  logic clk = 0, resetn = 0, start_valid = 0, res_ready = 0;
  logic [9:0] vl = 0;
  logic [2:0] vsew = 0, cur_vsew = 0;
  logic [127:0] vd_old = 0, vs1 = 0, vs2 = 0;
  logic start_ready, alu_run, res_valid, err;
  logic [9:0] alu_index;
  logic [3:0] alu_in_reg_offset;
  logic [63:0] alu_vd;
  logic [127:0] result;
  int n_checks = 0, n_fail = 0;
  int idx_q[$], off_q[$];

  always #5 clk = ~clk;

  vec_alu_seq #(.VLEN(128), .LANE_WIDTH(4)) dut (
    .clk(clk), .resetn(resetn), .start_valid(start_valid), .start_ready(start_ready),
    .vl(vl), .vsew(vsew), .vd_old(vd_old), .alu_run(alu_run), .alu_index(alu_index),
    .alu_in_reg_offset(alu_in_reg_offset), .alu_vd(alu_vd), .res_valid(res_valid),
    .res_ready(res_ready), .result(result), .err(err)
  );

  // 16-bit lane add stub: carry chains across offsets of one element
  logic carry_q = 0, cout;
  logic [127:0] sa, sb;
  logic [16:0] sum, m;
  int sw, cwb;
  always_comb begin
    sw = 8 << cur_vsew[1:0];
    cwb = sw > 16 ? 16 : sw;
    m = (17'd1 << cwb) - 17'd1;
    sa = vs1 >> alu_index;
    sb = vs2 >> alu_index;
    sum = 17'(sa[15:0] & m[15:0]) + 17'(sb[15:0] & m[15:0]) + 17'((alu_in_reg_offset != 0) ? carry_q : 1'b0);
    cout = sum[cwb];
    alu_vd = 64'(sum & m);
  end
  always @(posedge clk) if (alu_run) carry_q <= cout;

  function automatic logic [127:0] ref_res(input logic [127:0] old, a, b, input logic [2:0] vs, input int l);
    logic [127:0] r, ta, tb;
    logic [63:0] mk, s;
    int sew, n;
    r = old;
    if (vs > 3) return r;
    sew = 8 << vs;
    n = l < 128 / sew ? l : 128 / sew;
    mk = sew == 64 ? '1 : (64'd1 << sew) - 64'd1;
    for (int e = 0; e < n; e++) begin
      ta = a >> (e * sew);
      tb = b >> (e * sew);
      s = (ta[63:0] + tb[63:0]) & mk;
      r = (r & ~(128'(mk) << (e * sew))) | (128'(s) << (e * sew));
    end
    return r;
  endfunction

  function automatic int exp_runs(input logic [2:0] vs, input int l);
    int sew = 8 << vs;
    int n = l < 128 / sew ? l : 128 / sew;
    if (vs > 3) return 0;
    return n * (sew > 16 ? sew / 16 : 1);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_op(input logic [2:0] vs, input logic [9:0] l, input logic [127:0] old, a, b,
                       output int runs, output int lat, output logic [127:0] res, output logic e,
                       output logic post_rv, output logic post_err, output logic post_sr);
    @(negedge clk);
    vs1 = a; vs2 = b; cur_vsew = vs;
    start_valid = 1; vsew = vs; vl = l; vd_old = old;
    idx_q.delete(); off_q.delete();
    runs = 0; lat = -1;
    @(negedge clk);
    start_valid = 0;
    for (int k = 1; k <= 300; k++) begin
      if (alu_run) begin
        runs++;
        idx_q.push_back(int'(alu_index));
        off_q.push_back(int'(alu_in_reg_offset));
      end
      if (res_valid) begin lat = k; break; end
      @(negedge clk);
    end
    res = result; e = err;
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    post_rv = res_valid; post_err = err; post_sr = start_ready;
  endtask

  task automatic test_reset();
    resetn = 0;
    repeat (2) @(negedge clk);
    n_checks++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL reset_start_ready got %b exp 1", start_ready); end
    n_checks++; if (alu_run !== 1'b0) begin n_fail++; $display("FAIL reset_alu_run got %b exp 0", alu_run); end
    n_checks++; if (alu_index !== 10'd0) begin n_fail++; $display("FAIL reset_alu_index got %0d exp 0", alu_index); end
    n_checks++; if (alu_in_reg_offset !== 4'd0) begin n_fail++; $display("FAIL reset_offset got %0d exp 0", alu_in_reg_offset); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
    n_checks++; if (result !== 128'd0) begin n_fail++; $display("FAIL reset_result got %h exp 0", result); end
    resetn = 1;
    @(negedge clk);
  endtask

  task automatic test_sew32_add();
    int runs, lat; logic [127:0] res, old; logic e, prv, perr, psr;
    old = rnd128();
    do_op(3'd2, 10'd4, old, {4{32'h0000FFFF}}, {4{32'h0000FFFF}}, runs, lat, res, e, prv, perr, psr);
    n_checks++; if (runs !== 8) begin n_fail++; $display("FAIL sew32_runs got %0d exp 8", runs); end
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL sew32_valid_cycle got %0d exp 9", lat); end
    for (int i = 0; i < runs && i < 8; i++) begin
      n_checks++; if (off_q[i] !== i % 2) begin n_fail++; $display("FAIL sew32_offset[%0d] got %0d exp %0d", i, off_q[i], i % 2); end
      n_checks++; if (idx_q[i] !== i * 16) begin n_fail++; $display("FAIL sew32_index[%0d] got %0d exp %0d", i, idx_q[i], i * 16); end
    end
    n_checks++; if (res !== {4{32'h0001FFFE}}) begin n_fail++; $display("FAIL sew32_result got %h exp %h", res, {4{32'h0001FFFE}}); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL sew32_err got %b exp 0", e); end
    n_checks++; if (prv !== 1'b0 || psr !== 1'b1) begin n_fail++; $display("FAIL sew32_release got rv=%b sr=%b exp rv=0 sr=1", prv, psr); end
  endtask

  task automatic test_sew8_tail();
    int runs, lat; logic [127:0] res, a, b, exp_r, tail; logic e, prv, perr, psr;
    a = rnd128(); b = rnd128();
    exp_r = ref_res({16{8'hAA}}, a, b, 3'd0, 3);
    do_op(3'd0, 10'd3, {16{8'hAA}}, a, b, runs, lat, res, e, prv, perr, psr);
    tail = res >> 24;
    n_checks++; if (runs !== 3) begin n_fail++; $display("FAIL sew8_runs got %0d exp 3", runs); end
    for (int i = 0; i < runs && i < 3; i++) begin
      n_checks++; if (idx_q[i] !== i * 8) begin n_fail++; $display("FAIL sew8_index[%0d] got %0d exp %0d", i, idx_q[i], i * 8); end
    end
    n_checks++; if (res !== exp_r) begin n_fail++; $display("FAIL sew8_result got %h exp %h", res, exp_r); end
    n_checks++; if (tail[103:0] !== {13{8'hAA}}) begin n_fail++; $display("FAIL sew8_tail got %h exp all aa", tail[103:0]); end
  endtask

  task automatic test_vl_edges();
    int runs, lat; logic [127:0] res, old, a, b, exp_r; logic e, prv, perr, psr;
    old = rnd128(); a = rnd128(); b = rnd128();
    do_op(3'd1, 10'd0, old, a, b, runs, lat, res, e, prv, perr, psr);
    n_checks++; if (runs !== 0) begin n_fail++; $display("FAIL vl0_runs got %0d exp 0", runs); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL vl0_valid_cycle got %0d exp 1", lat); end
    n_checks++; if (res !== old) begin n_fail++; $display("FAIL vl0_result got %h exp %h", res, old); end
    exp_r = ref_res(old, a, b, 3'd1, 50);
    do_op(3'd1, 10'd50, old, a, b, runs, lat, res, e, prv, perr, psr);
    n_checks++; if (runs !== 8) begin n_fail++; $display("FAIL vl50_runs got %0d exp 8", runs); end
    n_checks++; if (res !== exp_r) begin n_fail++; $display("FAIL vl50_result got %h exp %h", res, exp_r); end
  endtask

  task automatic test_illegal_vsew();
    int runs, lat; logic [127:0] res, old; logic e, prv, perr, psr;
    old = rnd128();
    do_op(3'd5, 10'd4, old, rnd128(), rnd128(), runs, lat, res, e, prv, perr, psr);
    n_checks++; if (runs !== 0) begin n_fail++; $display("FAIL illegal_runs got %0d exp 0", runs); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL illegal_valid_cycle got %0d exp 1", lat); end
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL illegal_err got %b exp 1", e); end
    n_checks++; if (res !== old) begin n_fail++; $display("FAIL illegal_result got %h exp %h", res, old); end
    n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL illegal_err_clear got %b exp 0", perr); end
  endtask

  task automatic test_random();
    int runs, lat, l, er; logic [2:0] vs; logic [127:0] res, old, a, b, exp_r; logic e, prv, perr, psr;
    for (int t = 0; t < 24; t++) begin
      vs = 3'($urandom_range(0, 3)); l = $urandom_range(0, 70);
      old = rnd128(); a = rnd128(); b = rnd128();
      exp_r = ref_res(old, a, b, vs, l);
      er = exp_runs(vs, l);
      do_op(vs, 10'(l), old, a, b, runs, lat, res, e, prv, perr, psr);
      n_checks++; if (res !== exp_r) begin n_fail++; $display("FAIL rand%0d_result vsew=%0d vl=%0d got %h exp %h", t, vs, l, res, exp_r); end
      n_checks++; if (runs !== er || lat !== er + 1) begin n_fail++; $display("FAIL rand%0d_timing got runs=%0d lat=%0d exp runs=%0d lat=%0d", t, runs, lat, er, er + 1); end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] snap; int lat;
    @(negedge clk);
    vs1 = rnd128(); vs2 = rnd128(); cur_vsew = 3'd3;
    start_valid = 1; vsew = 3'd3; vl = 10'd2; vd_old = rnd128();
    @(negedge clk);
    vsew = 3'd0; vl = 10'd16;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      if (res_valid) begin lat = k; break; end
      @(negedge clk);
    end
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL bp_valid_cycle got %0d exp 9", lat); end
    snap = result;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++; if (res_valid !== 1'b1 || result !== snap || start_ready !== 1'b0 || alu_run !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d got rv=%b sr=%b run=%b res=%h exp rv=1 sr=0 run=0 res=%h", k, res_valid, start_ready, alu_run, result, snap);
      end
    end
    start_valid = 0; res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    @(negedge clk);
    n_checks++; if (start_ready !== 1'b1 || alu_run !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_no_queue got sr=%b run=%b rv=%b exp sr=1 run=0 rv=0", start_ready, alu_run, res_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    vs1 = rnd128(); vs2 = rnd128(); cur_vsew = 3'd3;
    start_valid = 1; vsew = 3'd3; vl = 10'd2; vd_old = rnd128();
    @(negedge clk);
    start_valid = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (alu_run !== 1'b1) begin n_fail++; $display("FAIL midrun_running got %b exp 1", alu_run); end
    resetn = 0;
    @(negedge clk);
    n_checks++; if (start_ready !== 1'b1 || alu_run !== 1'b0 || res_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL midrun_ctrl got sr=%b run=%b rv=%b err=%b exp 1 0 0 0", start_ready, alu_run, res_valid, err);
    end
    n_checks++; if (alu_index !== 10'd0 || alu_in_reg_offset !== 4'd0) begin
      n_fail++; $display("FAIL midrun_index got idx=%0d off=%0d exp 0 0", alu_index, alu_in_reg_offset);
    end
    n_checks++; if (result !== 128'd0) begin n_fail++; $display("FAIL midrun_result got %h exp 0", result); end
    resetn = 1;
    repeat (3) @(negedge clk);
    n_checks++; if (res_valid !== 1'b0 || alu_run !== 1'b0) begin n_fail++; $display("FAIL midrun_after got rv=%b run=%b exp 0 0", res_valid, alu_run); end
  endtask

  initial begin
    test_reset();
    test_sew32_add();
    test_sew8_tail();
    test_vl_edges();
    test_illegal_vsew();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vec_alu_seq.md
Name: vec_alu_seq

Overview:
- Sequencer and result collector placed directly upstream and downstream of the single-lane vector ALU.
- On a start handshake it walks the active elements of a vector operation chunk by chunk. For each chunk it drives the ALU's run, index and in-register-offset inputs.
- It captures the ALU's combinational vd result in the same cycle and packs it into a VLEN-bit destination image.
- It holds the finished image until the write-back stage accepts it.

Parameters:
- VLEN, 128, vector register width in bits (power of two, 64..512).
- LANE_WIDTH, 4, log2 of lane width in bits; lane = 2^LANE_WIDTH bits (3..6). Must match the ALU instance.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- start_valid  in  1  operation request
- start_ready  out  1  block idle, request accepted when both are high
- vl  in  10  number of elements to process
- vsew  in  3  element width code; SEW = 8 << vsew; 0..3 legal
- vd_old  in  VLEN  prior destination contents, latched at accept (tail-undisturbed source)
- alu_run  out  1  ALU enable
- alu_index  out  10  bit index of current chunk in vs2/vd
- alu_in_reg_offset  out  4  chunk number within current element
- alu_vd  in  64  ALU result; low min(SEW,lane) bits valid
- res_valid  out  1  result image valid
- res_ready  in  1  write-back accepts result
- result  out  VLEN  destination image
- err  out  1  sticky illegal-vsew flag for the held result

Behaviour:
- Reset (resetn low at clk edge, any state): state IDLE; start_ready=1; alu_run=0; alu_index=0; alu_in_reg_offset=0; res_valid=0; err=0; result=0.
- Derived per-operation values:
  - lane = 2^LANE_WIDTH.
  - chunks = SEW>lane ? SEW/lane : 1.
  - cw = min(SEW, lane) bits captured per chunk.
  - vlmax = VLEN/SEW.
  - vl_eff = min(vl, vlmax).
- FSM IDLE:
  - On start_valid && start_ready, latch vsew, vl_eff, and result <= vd_old.
  - If vsew>3: err=1, go DONE.
  - Else if vl_eff==0: go DONE.
  - Else: elem=0, chunk=0, go RUN.
- FSM RUN:
  - Every cycle: alu_run=1, alu_in_reg_offset=chunk, alu_index=elem*SEW + chunk*lane.
  - Same edge: result[alu_index +: cw] <= alu_vd[cw-1:0].
  - Advance chunk; at chunk==chunks-1, chunk=0 and elem++.
  - After the last chunk of element vl_eff-1, go DONE with alu_run=0 next cycle.
  - Chunks of one element are issued in consecutive cycles with no bubble, because the ALU's registered carry depends on back-to-back offsets.
  - Total RUN cycles = vl_eff*chunks.
- FSM DONE:
  - res_valid=1; result and err stable.
  - On res_ready, go IDLE, res_valid=0, and err clears the following cycle.
  - start_ready=0 in RUN and DONE.
- alu_run, alu_index and alu_in_reg_offset are registered outputs. The first chunk is presented the cycle after accept. alu_run is high only in RUN.
- Tail elements (>= vl_eff) and bits above cw within an element are never written and keep their vd_old value.
- start_valid outside IDLE is ignored; no queuing.
- Reset mid-RUN aborts the operation: result clears, no res_valid.
- alu_index width: VLEN-1 must fit in 10 bits (VLEN <= 512).

Decomposition:
- Shared vector package holds:
  - vsew codes and the SEW decode function.
  - op_type encodings (VV=001, VX=010, VI=100).
  - ALU opcode constants (vadd=000000, vand=001001, vor=001010, vxor=001011).
  - State encoding IDLE/RUN/DONE.
- One sub-module is natural: vec_elem_counter, holding the elem/chunk counter pair and index generation. The FSM and packing stay in the top.

Test Plan:
- VLEN=128, LANE_WIDTH=4, vsew=2 (SEW=32), vl=4, ALU vadd with vs1=vs2=all 0x0000FFFF:
  - Exactly 8 RUN cycles.
  - alu_in_reg_offset sequence 0,1,0,1,…
  - alu_index sequence 0,16,32,…,112.
  - result = four 0x0001FFFE words; res_valid rises the cycle after the last chunk.
- vsew=0 (SEW=8, cw=8), vl=3, vd_old=all 0xAA:
  - 3 RUN cycles with alu_index 0,8,16.
  - result bytes 0..2 from ALU; bytes 3..15 remain 0xAA.
- vl=0 or vl=50 with vsew=1:
  - vl=0: zero RUN cycles, result=vd_old, res_valid the cycle after accept.
  - vl=50: clamped to 8 elements, 8 RUN cycles.
- vsew=5: no alu_run, err=1 with res_valid; err clears after res_ready.
- Back-pressure and reset:
  - Hold res_ready=0 for 10 cycles: result and res_valid stable, start_valid ignored.
  - Assert resetn=0 mid-RUN: next cycle IDLE, all outputs at reset values.
